arm_operand_stage: RTL
======================

ARM_OPERAND_STAGE -- requirements
Module: arm_operand_stage

Interface
REQ-001 SHALL have parameter NUM_RD: default 3; number of register read ports.
REQ-002 SHALL have parameter NUM_FWD: default 2; number of forwarding sources, index 0 = youngest (EX), increasing index = older.
REQ-003 SHALL have parameter DATA_W: default 32; operand width.
REQ-004 SHALL have parameter CTRL_W: default 24; opaque decoded-control bundle width.
REQ-005 SHALL have parameter CNT_W: default 16; stall counter width.
REQ-006 SHALL have parameter PC_REG: default 4'd15; register number never forwarded.
REQ-007 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port in_valid  input  1  decoded instruction present.
REQ-010 SHALL have port in_ready  output  1  stage accepts this cycle.
REQ-011 SHALL have port in_ctrl  input  CTRL_W  decoded control bundle.
REQ-012 SHALL have port in_halt  input  1  instruction is a halt.
REQ-013 SHALL have port rd_num  input  4*NUM_RD  read register numbers, port p at [4p+3:4p].
REQ-014 SHALL have port rd_use  input  NUM_RD  bit p = port p really read.
REQ-015 SHALL have port rf_data  input  DATA_W*NUM_RD  register-file read data.
REQ-016 SHALL have port fwd_we  input  NUM_FWD  source s writes a register.
REQ-017 SHALL have port fwd_rd  input  4*NUM_FWD  source destination numbers.
REQ-018 SHALL have port fwd_pending  input  NUM_FWD  source result not yet available (load, MAC).
REQ-019 SHALL have port fwd_data  input  DATA_W*NUM_FWD  source result data.
REQ-020 SHALL have port flush  input  1  kill output register contents and current acceptance.
REQ-021 SHALL have port out_valid  output  1  output register holds an issued instruction.
REQ-022 SHALL have port out_ready  input  1  EX consumes output this cycle.
REQ-023 SHALL have port out_ctrl  output  CTRL_W  registered control bundle.
REQ-024 SHALL have port out_opnd  output  DATA_W*NUM_RD  registered resolved operands.
REQ-025 SHALL have port halted  output  1  sticky halt flag.
REQ-026 SHALL have port stall_cnt  output  CNT_W  saturating hazard-stall cycle count.

Function
REQ-027 SHALL compute per port p: match[s] = rd_use[p] & fwd_we[s] & (fwd_rd[s]==rd_num[p]) & (rd_num[p]!=PC_REG).
REQ-028 SHALL select the lowest-index matching source; no match -> rf_data port p.
REQ-029 SHALL assert hazard when the selected source of any used port has fwd_pending=1; pending state of older, unselected sources SHALL be ignored.
REQ-030 SHALL define slot_free = ~out_valid | out_ready; in_ready = ~rst & ~halted & ~hazard & slot_free & ~flush.
REQ-031 SHALL define accept = in_valid & in_ready.
REQ-032 SHALL, on accept with in_halt=0, load out_ctrl, out_opnd (forwarded values) and set out_valid=1 next cycle (latency 1).
REQ-033 SHALL, on accept with in_halt=1, set halted=1 and out_valid=0; halt instruction never issued.
REQ-034 SHALL, when out_ready=1 and no accept, clear out_valid (bubble); out_ctrl/out_opnd hold.
REQ-035 SHALL, when out_valid=1 and out_ready=0, hold all output registers unchanged.
REQ-036 SHALL, on flush, clear out_valid next cycle regardless of out_ready; no accept and no halted set that cycle.
REQ-037 SHALL keep halted=1 until rst; in_ready=0 while halted.
REQ-038 SHALL increment stall_cnt on every cycle with in_valid & hazard & ~flush & ~halted, saturating at all-ones.

Reset
REQ-039 SHALL, on rst=1 at a clock edge, set out_valid=0, halted=0, stall_cnt=0, out_ctrl=0, out_opnd=0.
REQ-040 SHALL give rst priority over flush, accept and out_ready; mid-stall reset clears everything, no partial issue.

Verification
REQ-041 No-hazard issue: rd_num={r3,r2,r1}, rd_use=3'b111, rf_data={30,20,10}, fwd_we=0, out_ready=1 -> next cycle out_valid=1, out_opnd={30,20,10}.
REQ-042 Priority: fwd_we=2'b11, fwd_rd={r2,r2}, fwd_data={0xBBBB,0xAAAA}, port0 reads r2 -> out_opnd port0=0xAAAA; port reading r15 with fwd_rd=r15 -> rf_data.
REQ-043 Load-use: fwd_pending[0]=1 matching port1 for 2 cycles -> in_ready=0, stall_cnt=2, then issue with fwd_data[0] after pending drops.
REQ-044 Backpressure: out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs stable; out_ready=1 -> next instruction loaded same edge.
REQ-045 Halt/flush: in_halt=1 accepted -> halted=1, out_valid=0, in_ready=0 forever; repeat with flush=1 same cycle -> halted stays 0.
REQ-046 Saturation: CNT_W=2, hazard 5 cycles -> stall_cnt=3; rst=1 -> stall_cnt=0, out_valid=0.

Source files
------------

// File: rtl/arm_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : arm_operand_stage
//  Purpose  : Operand-resolution stage between decode and execute. Resolves
//             each register read port against a prioritised set of
//             forwarding sources, detects load-use style hazards, and holds
//             the issued instruction in a single output register with
//             valid/ready handshaking. Also tracks a sticky halt flag and a
//             saturating count of hazard-stall cycles.
//  Ports    :
//    clk, rst        - clock, synchronous active-high reset
//    in_valid/ready  - decode-side handshake; in_ctrl, in_halt payload
//    rd_num/use      - per-port register number (4 bits) and use flag
//    rf_data         - per-port register-file read data
//    fwd_we/rd/      - per-source write enable, destination, pending flag
//    pending/data      and result data (index 0 = youngest)
//    flush           - kill output register and current acceptance
//    out_valid/ready - execute-side handshake; out_ctrl, out_opnd payload
//    halted          - sticky halt flag
//    stall_cnt       - saturating hazard-stall cycle counter
//  Revision : 1.0  initial release
// ============================================================================
module arm_operand_stage #(
  parameter int         NUM_RD  = 3,
  parameter int         NUM_FWD = 2,
  parameter int         DATA_W  = 32,
  parameter int         CTRL_W  = 24,
  parameter int         CNT_W   = 16,
  parameter logic [3:0] PC_REG  = 4'd15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic                      in_halt,
  input  logic [4*NUM_RD-1:0]       rd_num,
  input  logic [NUM_RD-1:0]         rd_use,
  input  logic [DATA_W*NUM_RD-1:0]  rf_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [4*NUM_FWD-1:0]      fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [DATA_W*NUM_RD-1:0]  out_opnd,
  output logic                      halted,
  output logic [CNT_W-1:0]          stall_cnt
);

  // --------------------------------------------------------------------------
  // Operand resolution
  // --------------------------------------------------------------------------
  logic [DATA_W*NUM_RD-1:0] opnd_fwd;
  logic [NUM_RD-1:0]        port_hazard;
  logic                     hazard;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [3:0]        num;
    logic [DATA_W-1:0] sel_data;
    logic              sel_pend;

    assign num = rd_num[4*p +: 4];

    // Scan from oldest to youngest so the youngest (lowest-index) match
    // overwrites any older one. Only the selected source's pending flag
    // matters; an older pending result that is shadowed is irrelevant.
    always_comb begin
      sel_data = rf_data[DATA_W*p +: DATA_W];
      sel_pend = 1'b0;
      for (int s = NUM_FWD - 1; s >= 0; s--) begin
        if (rd_use[p] && fwd_we[s] && (fwd_rd[4*s +: 4] == num) && (num != PC_REG)) begin
          sel_data = fwd_data[DATA_W*s +: DATA_W];
          sel_pend = fwd_pending[s];
        end
      end
    end

    assign opnd_fwd[DATA_W*p +: DATA_W] = sel_data;
    assign port_hazard[p]               = sel_pend;
  end : g_port

  assign hazard = |port_hazard;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic                     out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]        out_ctrl_q,  out_ctrl_d;
  logic [DATA_W*NUM_RD-1:0] out_opnd_q,  out_opnd_d;
  logic                     halted_q,    halted_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic                     slot_free;
  logic                     accept;
  logic                     stall_inc;

  assign slot_free = ~out_valid_q | out_ready;
  assign in_ready  = ~rst & ~halted_q & ~hazard & slot_free & ~flush;
  assign accept    = in_valid & in_ready;
  assign stall_inc = in_valid & hazard & ~flush & ~halted_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_opnd_d  = out_opnd_q;
    halted_d    = halted_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      // accept is already suppressed by flush through in_ready
      out_valid_d = 1'b0;
    end else if (accept) begin
      if (in_halt) begin
        // A halt is consumed here and never reaches execute
        halted_d    = 1'b1;
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        out_ctrl_d  = in_ctrl;
        out_opnd_d  = opnd_fwd;
      end
    end else if (out_ready) begin
      // Consumed with nothing behind it: bubble, payload left as-is
      out_valid_d = 1'b0;
    end

    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_opnd_q  <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_opnd_q  <= out_opnd_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_opnd  = out_opnd_q;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

endmodule : arm_operand_stage
`default_nettype wire
